// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ requesters, one-entry output stage.
// Optional same-cycle read bypass when RFW_BYPASS_EN is defined.
module regfile_write_arbiter #(
    parameter int NREQ     = 2,
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*5-1:0]        req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     wr_en,
    output logic [4:0]               wr_addr,
    output logic [DATA_W-1:0]        wr_data
`ifdef RFW_BYPASS_EN
    ,
    input  logic [4:0]               byp_rd_addr,
    output logic                     byp_hit,
    output logic [DATA_W-1:0]        byp_data
`endif
);

    localparam int unsigned PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned ADDR_W = 5;
    localparam logic [ADDR_W-1:0] XZR = 5'd31;

    logic [PTR_W-1:0]  r_ptr;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    logic              w_found;
    logic              w_xfer;
    logic              w_drop;
    logic [PTR_W-1:0]  w_idx;
    logic [PTR_W-1:0]  w_gidx;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic [ADDR_W-1:0] w_addr_arr [NREQ];
    logic [DATA_W-1:0] w_data_arr [NREQ];

    // Unpack the flat request buses into per-requester lanes
    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign w_addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign w_data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    // Search from the pointer for the first valid requester
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gidx  = w_idx;
            end
        end
    end

    assign w_sel_addr = w_addr_arr[w_gidx];
    assign w_sel_data = w_data_arr[w_gidx];
    assign w_xfer     = w_found && !reset;
    assign w_drop     = (ZERO_REG != 0) && (w_sel_addr == XZR);
    assign w_ptr_nxt  = (int'(w_gidx) == NREQ - 1) ? '0 : w_gidx + PTR_W'(1);

    always_comb begin
        req_ready = '0;
        if (w_xfer) begin
            req_ready[w_gidx] = 1'b1;
        end
    end

    // Output stage; XZR writes are acknowledged but never enabled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_xfer && !w_drop;
            if (w_xfer) begin
                r_ptr     <= w_ptr_nxt;
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

`ifdef RFW_BYPASS_EN
    // Forward the in-flight write to a same-cycle reader
    always_comb begin
        byp_hit  = r_wr_en && (r_wr_addr == byp_rd_addr)
                   && !((ZERO_REG != 0) && (byp_rd_addr == XZR));
        byp_data = byp_hit ? r_wr_data : '0;
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scoreboard bench for regfile_write_arbiter (NREQ=2, DATA_W=64, ZERO_REG=1).
// Bypass checks are included when RFW_BYPASS_EN is defined.
module tb_regfile_write_arbiter;

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [9:0]  req_addr;
    logic [127:0] req_data;
    logic [1:0]  req_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
`ifdef RFW_BYPASS_EN
    logic [4:0]  byp_rd_addr = 5'd0;
    logic        byp_hit;
    logic [63:0] byp_data;
`endif

    wr_t         exp_q[$];
    logic [4:0]  last_addr = 5'd0;
    logic [63:0] last_data = 64'd0;
    logic [63:0] rf [32];
    int          n_cmp = 0;
    int          n_err = 0;

    regfile_write_arbiter #(.NREQ(2), .DATA_W(64), .ZERO_REG(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
`ifdef RFW_BYPASS_EN
        ,
        .byp_rd_addr (byp_rd_addr),
        .byp_hit     (byp_hit),
        .byp_data    (byp_data)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive, check grant, queue the expected write, then check the output stage
    task automatic cycle(input string tag, input logic rst, input logic [1:0] v,
                         input logic [4:0] a0, input logic [4:0] a1,
                         input logic [63:0] d0, input logic [63:0] d1,
                         input logic [1:0] exp_rdy);
        wr_t e;
        reset     = rst;
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
        #1;
        chk({tag, ".ready"}, 64'(req_ready), 64'(exp_rdy));
        if (rst) begin
            e = '{en: 1'b0, addr: 5'd0, data: 64'd0};
        end else if (exp_rdy[0]) begin
            e = '{en: (a0 != 5'd31), addr: a0, data: d0};
        end else if (exp_rdy[1]) begin
            e = '{en: (a1 != 5'd31), addr: a1, data: d1};
        end else begin
            e = '{en: 1'b0, addr: last_addr, data: last_data};
        end
        last_addr = e.addr;
        last_data = e.data;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s.queue: got empty expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".wr_en"},   64'(wr_en),   64'(e.en));
            chk({tag, ".wr_addr"}, 64'(wr_addr), 64'(e.addr));
            chk({tag, ".wr_data"}, wr_data,      e.data);
        end
        if (wr_en) rf[wr_addr] = wr_data;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 64'd0;

        // Reset held two cycles with both requesters valid
        cycle("rst0", 1'b1, 2'b11, 5'd1, 5'd2, 64'h1, 64'h2, 2'b00);
        cycle("rst1", 1'b1, 2'b11, 5'd1, 5'd2, 64'h1, 64'h2, 2'b00);
        cycle("idle0", 1'b0, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 2'b00);

        // Single write from requester 0
        cycle("single", 1'b0, 2'b01, 5'd5, 5'd0, 64'hDEAD_BEEF, 64'h0, 2'b01);
`ifdef RFW_BYPASS_EN
        byp_rd_addr = 5'd5;
        #1;
        chk("byp5.hit",  64'(byp_hit), 64'd1);
        chk("byp5.data", byp_data,     64'hDEAD_BEEF);
        byp_rd_addr = 5'd6;
        #1;
        chk("byp6.hit",  64'(byp_hit), 64'd0);
        chk("byp6.data", byp_data,     64'd0);
`endif
        cycle("single_after", 1'b0, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 2'b00);

        // Reset mid-operation: valid requester gets no grant, pointer returns to 0
        cycle("rst_mid", 1'b1, 2'b11, 5'd9, 5'd9, 64'h9, 64'h9, 2'b00);

        // Contention: grants alternate 0,1,0,1 with no bubbles
        cycle("rr0", 1'b0, 2'b11, 5'd1, 5'd2, 64'h11, 64'h22, 2'b01);
        cycle("rr1", 1'b0, 2'b11, 5'd1, 5'd2, 64'h11, 64'h22, 2'b10);
        cycle("rr2", 1'b0, 2'b11, 5'd1, 5'd2, 64'h11, 64'h22, 2'b01);
        cycle("rr3", 1'b0, 2'b11, 5'd1, 5'd2, 64'h11, 64'h22, 2'b10);

        // Same destination from both: serialized, later grant wins
        cycle("same0", 1'b0, 2'b11, 5'd7, 5'd7, 64'd1, 64'd2, 2'b01);
        cycle("same1", 1'b0, 2'b10, 5'd7, 5'd7, 64'd1, 64'd2, 2'b10);
        chk("rf7.final", rf[7], 64'd2);

        // Zero register: acknowledged, never written, pointer wraps to 0
        cycle("xzr", 1'b0, 2'b10, 5'd0, 5'd31, 64'h0, 64'd9, 2'b10);
        cycle("xzr_ptr", 1'b0, 2'b11, 5'd3, 5'd4, 64'h33, 64'h44, 2'b01);
        cycle("idle1", 1'b0, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 2'b00);
        chk("rf31.untouched", rf[31], 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
